// File: rtl/branch_pc_unit_pkg.sv
// Shared constants for the fetch-side PC generator and its pipeline registers.
package branch_pc_unit_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned INSN_BYTES   = 4;

  // Next-PC select encodings driven by the predictor
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_ID  = 2'b01;
  localparam logic [1:0] PCSRC_EX  = 2'b10;

endpackage

// File: rtl/branch_meta_reg.sv
// Pipeline register with valid bit, hold (stall) and flush (bubble) controls.
module branch_meta_reg #(
  parameter int unsigned   W        = 32,
  parameter logic [W-1:0]  RST_DATA = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         hold_i,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  // Flush beats hold; a bubble carries zeroed payload so nothing goes unknown
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o <= 1'b0;
      data_o  <= RST_DATA;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (!hold_i) begin
      valid_o <= valid_i;
      data_o  <= data_i;
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC generator plus IF/ID and ID/EX branch metadata; resolves BEQ in EX.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            id_branch_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic            predict_i,
  input  logic [1:0]      pcsrc_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_target_o,
  output logic            ex_branch_o,
  output logic            ex_taken_o,
  output logic [XLEN-1:0] ex_recover_pc_o
);

  localparam int unsigned IFID_W = XLEN;
  localparam int unsigned IDEX_W = 2 * XLEN + 2;
  // Idle ID/EX image looks predicted-taken from PC 0, so the recover PC reads 4
  localparam logic [IDEX_W-1:0] IDEX_RST = {XLEN'(0), XLEN'(0), 1'b1, 1'b0};

  logic              ex_redirect_c;
  logic              id_redirect_c;
  logic [XLEN-1:0]   pc_next_c;
  logic              ifid_valid;
  logic              idex_valid;
  logic [IDEX_W-1:0] idex_d_c;
  logic [IDEX_W-1:0] idex_q;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_target;
  logic              ex_predict;
  logic              ex_is_branch;

  assign ex_redirect_c = pcsrc_i[1];
  assign id_redirect_c = (pcsrc_i == PCSRC_ID) && !stall_i;

  // Next fetch PC: EX recovery overrides everything, including a stall
  always_comb begin
    pc_next_c = pc_o + XLEN'(INSN_BYTES);
    if (ex_redirect_c) begin
      pc_next_c = ex_recover_pc_o;
    end else if (id_redirect_c) begin
      pc_next_c = id_target_o;
    end else if (stall_i) begin
      pc_next_c = pc_o;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_o <= RESET_PC;
    end else begin
      pc_o <= pc_next_c;
    end
  end

  branch_meta_reg #(
    .W        (IFID_W),
    .RST_DATA ('0)
  ) u_ifid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .hold_i  (stall_i),
    .flush_i (ex_redirect_c || id_redirect_c),
    .valid_i (1'b1),
    .data_i  (pc_o),
    .valid_o (ifid_valid),
    .data_o  (id_pc_o)
  );

  assign id_target_o = id_pc_o + id_imm_i;
  assign idex_d_c    = {id_pc_o, id_target_o, predict_i, id_branch_i & ifid_valid};

  branch_meta_reg #(
    .W        (IDEX_W),
    .RST_DATA (IDEX_RST)
  ) u_idex (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .hold_i  (1'b0),
    .flush_i (ex_redirect_c || stall_i),
    .valid_i (ifid_valid),
    .data_i  (idex_d_c),
    .valid_o (idex_valid),
    .data_o  (idex_q)
  );

  assign {ex_pc, ex_target, ex_predict, ex_is_branch} = idex_q;

  assign ex_branch_o     = idex_valid & ex_is_branch;
  assign ex_taken_o      = ex_branch_o & (ex_rs1_i == ex_rs2_i);
  assign ex_recover_pc_o = ex_predict ? (ex_pc + XLEN'(INSN_BYTES)) : ex_target;

endmodule
